req_encoder_8to3: RTL
=====================

# req_encoder_8to3

Sequential 8:3 request encoder with round-robin arbitration and a valid/ready output; the inverse of the register-file 3:8 write decoder. Eight one-bit request lines set sticky pending bits, and the block serves them one at a time as a 3-bit index. The consumer, for example a register-file port or writeback sequencer, feeds the accepted index back into the 3:8 decoder.

## Interface
- N, default 8: number of request lines; power of two, 2..32.
- IDX_W, default $clog2(N) = 3: width of the encoded index.

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  request capture enable; when low, `req` is ignored
- req  in  N  request pulses; bit i high at an edge sets pending[i]
- out_ready  in  1  consumer accepts `out_idx` this cycle
- out_valid  out  1  `out_idx` holds a granted request
- out_idx  out  IDX_W  encoded index of the granted request
- pending  out  N  current pending-request register
- coalesced  out  1  one-cycle pulse: a request hit an already-pending bit

## Operation
- Handshake: `hs = out_valid & out_ready`. clr = one-hot(out_idx) when hs, else 0.
- Pending update on every edge: pending <= (pending & ~clr) | (enable ? req : 0).
  - A set and a clear of the same bit in the same cycle: set wins. The bit stays pending as a new request.
- Round-robin pointer `ptr` (IDX_W bits):
  - After each hs, ptr <= (out_idx + 1) mod N.
  - Winner = first set bit of registered `pending`, scanning ptr, ptr+1, …, wrapping mod N.
- FSM, two states:
  - IDLE: out_valid = 0. If pending != 0, register the winner into out_idx and go to OFFER. Otherwise stay.
  - OFFER: out_valid = 1 and out_idx holds stable. On hs, clear the bit, update ptr, go to IDLE. Otherwise stay, with no timeout.
- Selection uses only registered `pending`. A same-cycle `req` is never granted combinationally.
- The granted bit stays set in `pending` until its hs.
- coalesced <= |(enable & req & pending & ~clr), registered.
  - A request on the bit under offer counts as coalesced, unless it arrives in the hs cycle.
  - Multiple coalesced bits in one cycle produce a single pulse.
- With enable low, capture stops, but already-pending requests are still served.

## Timing
- Reset (reset_n low, takes effect immediately without waiting for a clock edge):
  - pending = 0, ptr = 0, state = IDLE, out_valid = 0, out_idx = 0, coalesced = 0.
  - Asserting reset mid-OFFER drops out_valid immediately.
  - Release is synchronous to the next clk edge; the first capture is at the first edge with reset_n high.
- Latency: req sampled at edge t → pending visible after t → out_valid high after edge t+1.
- Throughput: at most one grant per 2 cycles, because IDLE is always one cycle after hs.
- out_idx changes only on the IDLE→OFFER transition and on reset.
- out_ready while out_valid = 0 has no effect.
- Wrap: ptr = N-1 after a grant of index N-2; a grant of index N-1 sets ptr to 0.

## Test plan
- Reset mid-offer: pending = 8'h24, out_valid = 1, out_ready = 0, then reset_n low between edges → out_valid = 0 and pending = 0 immediately. After release with no req, out_valid stays 0.
- Single request: req = 8'b0010_0000 for one edge, out_ready = 1 → out_valid high after the next edge with out_idx = 5. One cycle later, out_valid = 0 and pending = 0.
- Full burst: req = 8'hFF once, out_ready = 1 → out_idx 0,1,…,7, one grant every 2 cycles, exactly 8 handshakes, then pending = 0.
- Round-robin wrap: grant idx 5 (ptr = 6), then req = 8'b0100_0100 → order 6 then 2. Next, req = 8'h81 after a grant of 7 → order 0 then 7.
- Backpressure and coalescing: pending = 8'h08, out_ready = 0 for 10 cycles → out_idx = 3 stable. A req[3] pulse during this window → coalesced pulses once, pending stays 8'h08.
- Enable and same-cycle set/clear:
  - enable = 0 with req = 8'h0F → pending stays 0 and out_valid stays 0.
  - req[3] asserted in the hs cycle for idx 3, with pending[1] also set → pending[3] remains set, coalesced stays 0, and grants continue 3, then 1, then 3.

Source files
------------

// File: rtl/req_encoder_8to3.sv
// Sequential N:log2(N) request encoder: sticky pending bits served one at a time
// through round-robin arbitration and a valid/ready handshake.
module req_encoder_8to3 #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic             coalesced
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state_reg;
  logic [N-1:0]     pending_reg;
  logic [N-1:0]     pending_next;
  logic [N-1:0]     clr;
  logic [N-1:0]     req_in;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] out_idx_reg;
  logic [IDX_W-1:0] offset;
  logic [IDX_W-1:0] winner;
  logic             out_valid_reg;
  logic             coalesced_reg;
  logic             coalesced_next;
  logic             hs;
  logic [2*N-1:0]   doubled;
  logic [N-1:0]     rotated;

  assign hs = out_valid_reg & out_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_clr
      assign clr[gi] = hs && (out_idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Set is OR-ed in after the clear, so a same-cycle re-request survives the handshake.
  assign req_in         = enable ? req : '0;
  assign pending_next   = (pending_reg & ~clr) | req_in;
  assign coalesced_next = |(req_in & pending_reg & ~clr);

  // Rotate pending so bit 0 is the pointer position, then take the lowest set bit.
  assign doubled = {pending_reg, pending_reg};
  assign rotated = doubled[ptr_reg +: N];

  always_comb begin
    offset = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) offset = IDX_W'(k);
    end
  end

  // N is a power of two, so the IDX_W-bit sum wraps modulo N for free.
  assign winner = ptr_reg + offset;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      pending_reg   <= '0;
      ptr_reg       <= '0;
      out_idx_reg   <= '0;
      out_valid_reg <= 1'b0;
      coalesced_reg <= 1'b0;
    end else begin
      pending_reg   <= pending_next;
      coalesced_reg <= coalesced_next;
      case (state_reg)
        IDLE: begin
          if (|pending_reg) begin
            out_idx_reg   <= winner;
            out_valid_reg <= 1'b1;
            state_reg     <= OFFER;
          end
        end
        OFFER: begin
          if (hs) begin
            ptr_reg       <= out_idx_reg + 1'b1;
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign pending   = pending_reg;
  assign coalesced = coalesced_reg;

endmodule
